// File: rtl/rf_wb_pkg.sv
// Shared types for the register-file write-back scheduler.
// Holds the data width, register address width and the LL result entry layout.
package rf_wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
        logic [XLEN-1:0]   pc;
    } ll_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO of long-latency results.
// DEPTH must be a power of two so the pointers wrap naturally.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  ll_entry_t push_entry,
    input  logic      pop,
    output ll_entry_t head,
    output logic      full,
    output logic      empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push, do_pop;
    ll_entry_t     mem [DEPTH];

    always_comb begin
        full     = (count_q == (PW+1)'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
        head     = mem[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port owner: WB/LL arbiter, pending-destination scoreboard, starvation stall.
// Define RF_WB_BYPASS_EN to let an LL result write the RF in its acceptance cycle when the port is idle.
module rf_wb_scheduler
    import rf_wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    input  logic [XLEN-1:0]   wb_pc,
    input  logic              ll_issue,
    input  logic [REG_AW-1:0] ll_issue_rd,
    input  logic              ll_res_valid,
    output logic              ll_res_ready,
    input  logic [REG_AW-1:0] ll_res_rd,
    input  logic [XLEN-1:0]   ll_res_data,
    input  logic [XLEN-1:0]   ll_res_pc,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    output logic              issue_stall,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_a3,
    output logic [XLEN-1:0]   rf_wd,
    output logic [XLEN-1:0]   rf_pc
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [31:0]       pend_q, pend_d;
    logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
    logic              wb_valid, ll_accept, bypass, starve;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic              ll_wr;
    logic [REG_AW-1:0] ll_wr_rd;
    ll_entry_t         fifo_head, ll_in;

    assign ll_in = '{rd: ll_res_rd, data: ll_res_data, pc: ll_res_pc};

    rf_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (fifo_push),
        .push_entry (ll_in),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wb_valid     = wb_we && (wb_rd != '0);
        ll_res_ready = !fifo_full && !rst;
        ll_accept    = ll_res_valid && ll_res_ready && (ll_res_rd != '0);
        bypass       = 1'b0;
`ifdef RF_WB_BYPASS_EN
        bypass       = ll_accept && fifo_empty && !wb_valid;
`endif
        fifo_push    = ll_accept && !bypass;
        fifo_pop     = !wb_valid && !fifo_empty;

        rf_we    = 1'b0;
        rf_a3    = '0;
        rf_wd    = '0;
        rf_pc    = '0;
        ll_wr    = 1'b0;
        ll_wr_rd = '0;
        if (!rst) begin
            if (wb_valid) begin
                rf_we = 1'b1;
                rf_a3 = wb_rd;
                rf_wd = wb_data;
                rf_pc = wb_pc;
            end else if (!fifo_empty) begin
                rf_we    = 1'b1;
                rf_a3    = fifo_head.rd;
                rf_wd    = fifo_head.data;
                rf_pc    = fifo_head.pc;
                ll_wr    = 1'b1;
                ll_wr_rd = fifo_head.rd;
            end else if (bypass) begin
                rf_we    = 1'b1;
                rf_a3    = ll_res_rd;
                rf_wd    = ll_res_data;
                rf_pc    = ll_res_pc;
                ll_wr    = 1'b1;
                ll_wr_rd = ll_res_rd;
            end
        end

        // Clear before set so a re-issue to the register being retired stays pending.
        pend_d = pend_q;
        if (ll_wr) begin
            pend_d[ll_wr_rd] = 1'b0;
        end
        if (ll_issue && (ll_issue_rd != '0)) begin
            pend_d[ll_issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;

        starve_cnt_d = starve_cnt_q;
        if (fifo_pop) begin
            starve_cnt_d = '0;
        end else if (!fifo_empty && wb_valid && (starve_cnt_q != SW'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
        starve = (starve_cnt_q >= SW'(STARVE_LIMIT));

        issue_stall = !rst && (pend_q[id_rs1] || pend_q[id_rs2] ||
                               (pend_q[id_rd] && (id_rd != '0)) || starve);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q       <= '0;
            starve_cnt_q <= '0;
        end else begin
            pend_q       <= pend_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // The in-order pipeline must never write a register an LL op still owns.
    wb_to_pending_reg: assert property (@(posedge clk) disable iff (rst)
        !(wb_valid && pend_q[wb_rd]));

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: reference arbiter/FIFO model feeding an expected-write queue.
// Builds with or without RF_WB_BYPASS_EN; expectations follow the same macro.
module tb_rf_wb_scheduler;
    import rf_wb_pkg::*;

    localparam int FIFO_DEPTH = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_we;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_data, wb_pc;
    logic              ll_issue;
    logic [REG_AW-1:0] ll_issue_rd;
    logic              ll_res_valid, ll_res_ready;
    logic [REG_AW-1:0] ll_res_rd;
    logic [XLEN-1:0]   ll_res_data, ll_res_pc;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              issue_stall, rf_we;
    logic [REG_AW-1:0] rf_a3;
    logic [XLEN-1:0]   rf_wd, rf_pc;

    int n_cmp = 0;
    int n_err = 0;
    ll_entry_t ll_q[$];   // model of FIFO contents
    ll_entry_t exp_q[$];  // expected RF writes, in order

    always #5 clk = ~clk;

    rf_wb_scheduler #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_pc        (wb_pc),
        .ll_issue     (ll_issue),
        .ll_issue_rd  (ll_issue_rd),
        .ll_res_valid (ll_res_valid),
        .ll_res_ready (ll_res_ready),
        .ll_res_rd    (ll_res_rd),
        .ll_res_data  (ll_res_data),
        .ll_res_pc    (ll_res_pc),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_rd        (id_rd),
        .issue_stall  (issue_stall),
        .rf_we        (rf_we),
        .rf_a3        (rf_a3),
        .rf_wd        (rf_wd),
        .rf_pc        (rf_pc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs are already driven (just after a posedge). Model the cycle, sample at negedge,
    // then advance to just after the next posedge.
    task automatic cycle(input logic exp_stall);
        int        occ;
        bit        acc;
        bit        wrote;
        ll_entry_t w;
        ll_entry_t got;
        occ   = ll_q.size();
        acc   = ll_res_valid && (occ < FIFO_DEPTH);
        wrote = 1'b1;
        w     = '0;
        if (wb_we && wb_rd != 0) begin
            w = '{rd: wb_rd, data: wb_data, pc: wb_pc};
        end else if (occ > 0) begin
            w = ll_q.pop_front();
`ifdef RF_WB_BYPASS_EN
        end else if (acc && ll_res_rd != 0) begin
            w   = '{rd: ll_res_rd, data: ll_res_data, pc: ll_res_pc};
            acc = 1'b0;
`endif
        end else begin
            wrote = 1'b0;
        end
        if (acc && ll_res_rd != 0) ll_q.push_back('{rd: ll_res_rd, data: ll_res_data, pc: ll_res_pc});
        if (wrote) exp_q.push_back(w);

        @(negedge clk);
        check("ll_res_ready", {63'd0, ll_res_ready}, {63'd0, occ < FIFO_DEPTH});
        check("issue_stall", {63'd0, issue_stall}, {63'd0, exp_stall});
        check("rf_we", {63'd0, rf_we}, {63'd0, wrote});
        if (rf_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_rd", {59'd0, rf_a3}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                got = exp_q.pop_front();
                check("rf_a3", {59'd0, rf_a3}, {59'd0, got.rd});
                check("rf_wd", {32'd0, rf_wd}, {32'd0, got.data});
                check("rf_pc", {32'd0, rf_pc}, {32'd0, got.pc});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_ll(input logic v, input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] data,
                          input logic [XLEN-1:0] pc);
        ll_res_valid = v;
        ll_res_rd    = rd;
        ll_res_data  = data;
        ll_res_pc    = pc;
    endtask

    task automatic set_wb(input logic we, input logic [REG_AW-1:0] rd, input logic [XLEN-1:0] data);
        wb_we   = we;
        wb_rd   = rd;
        wb_data = data;
        wb_pc   = data + 32'h1000;
    endtask

    task automatic set_id(input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                          input logic [REG_AW-1:0] rd);
        id_rs1 = rs1;
        id_rs2 = rs2;
        id_rd  = rd;
    endtask

    initial begin
        rst = 1'b1;
        set_wb(1'b0, 5'd0, 32'd0);
        ll_issue = 1'b0;
        ll_issue_rd = 5'd0;
        set_ll(1'b1, 5'd1, 32'hDEAD_0001, 32'h10);
        set_id(5'd1, 5'd2, 5'd3);

        // Reset held two cycles with a valid LL result offered
        repeat (2) begin
            @(negedge clk);
            check("rst_rf_we", {63'd0, rf_we}, 64'd0);
            check("rst_ready", {63'd0, ll_res_ready}, 64'd0);
            check("rst_stall", {63'd0, issue_stall}, 64'd0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        set_ll(1'b0, 5'd0, 32'd0, 32'd0);
        cycle(1'b0);

        // WB only, then rd==0 no-write
        set_wb(1'b1, 5'd5, 32'h1234);
        cycle(1'b0);
        set_wb(1'b1, 5'd0, 32'h9999);
        cycle(1'b0);
        set_wb(1'b0, 5'd0, 32'd0);

        // Collision: WB x3 now, LL x7 next cycle
        set_wb(1'b1, 5'd3, 32'h33);
        set_ll(1'b1, 5'd7, 32'hAA, 32'h204);
        cycle(1'b0);
        set_wb(1'b0, 5'd0, 32'd0);
        set_ll(1'b0, 5'd0, 32'd0, 32'd0);
        cycle(1'b0);
        cycle(1'b0);

        // Idle port: bypass (same cycle) or one cycle later
        set_ll(1'b1, 5'd9, 32'h55, 32'h300);
        cycle(1'b0);
        set_ll(1'b0, 5'd0, 32'd0, 32'd0);
        cycle(1'b0);

        // Hazards on x4
        ll_issue = 1'b1; ll_issue_rd = 5'd4;
        set_id(5'd1, 5'd4, 5'd3);
        cycle(1'b0);
        ll_issue_rd = 5'd0;
        cycle(1'b1);
        ll_issue = 1'b0;
        set_id(5'd0, 5'd0, 5'd0);
        cycle(1'b0);
        set_id(5'd0, 5'd0, 5'd4);
        cycle(1'b1);
        set_id(5'd4, 5'd0, 5'd0);
        cycle(1'b1);
        set_ll(1'b1, 5'd0, 32'hDEAD, 32'h3F0);
        cycle(1'b1);
        set_ll(1'b0, 5'd0, 32'd0, 32'd0);
        cycle(1'b1);
        set_ll(1'b1, 5'd4, 32'h44, 32'h400);
        cycle(1'b1);
        set_ll(1'b0, 5'd0, 32'd0, 32'd0);
`ifdef RF_WB_BYPASS_EN
        cycle(1'b0);
`else
        cycle(1'b1);
`endif
        cycle(1'b0);

        // Re-issue of x11 in the cycle it retires: set wins
        ll_issue = 1'b1; ll_issue_rd = 5'd11;
        set_id(5'd11, 5'd0, 5'd0);
        cycle(1'b0);
        ll_issue = 1'b0;
        set_ll(1'b1, 5'd11, 32'hB1, 32'h500);
`ifdef RF_WB_BYPASS_EN
        ll_issue = 1'b1;
`endif
        cycle(1'b1);
        set_ll(1'b0, 5'd0, 32'd0, 32'd0);
        ll_issue = 1'b0;
`ifndef RF_WB_BYPASS_EN
        ll_issue = 1'b1;
`endif
        cycle(1'b1);
        ll_issue = 1'b0;
        cycle(1'b1);
        set_ll(1'b1, 5'd11, 32'hB2, 32'h504);
        cycle(1'b1);
        set_ll(1'b0, 5'd0, 32'd0, 32'd0);
`ifdef RF_WB_BYPASS_EN
        cycle(1'b0);
`else
        cycle(1'b1);
`endif
        cycle(1'b0);

        // Starvation: x6 and x8 queued behind continuous WB; FIFO full refuses x14
        set_id(5'd1, 5'd2, 5'd3);
        set_wb(1'b1, 5'd10, 32'hA0);
        set_ll(1'b1, 5'd6, 32'h66, 32'h600);
        cycle(1'b0);
        set_ll(1'b1, 5'd8, 32'h88, 32'h800);
        set_wb(1'b1, 5'd11, 32'hA1);
        cycle(1'b0);
        set_ll(1'b1, 5'd14, 32'hEE, 32'hE00);
        for (int k = 2; k <= 6; k++) begin
            set_wb(1'b1, 5'(10 + k), 32'hA0 + 32'(k));
            cycle(k >= 5);
        end
        set_wb(1'b0, 5'd0, 32'd0);
        cycle(1'b1);
        set_ll(1'b0, 5'd0, 32'd0, 32'd0);
        cycle(1'b0);
        cycle(1'b0);

        // Reset mid-operation discards queued x12 and its pending bit
        ll_issue = 1'b1; ll_issue_rd = 5'd12;
        cycle(1'b0);
        ll_issue = 1'b0;
        set_id(5'd12, 5'd2, 5'd3);
        set_wb(1'b1, 5'd13, 32'hD0);
        set_ll(1'b1, 5'd12, 32'hC2, 32'hC00);
        cycle(1'b1);
        set_wb(1'b0, 5'd0, 32'd0);
        set_ll(1'b0, 5'd0, 32'd0, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rf_we", {63'd0, rf_we}, 64'd0);
        check("midrst_ready", {63'd0, ll_res_ready}, 64'd0);
        check("midrst_stall", {63'd0, issue_stall}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ll_q.delete();
        cycle(1'b0);
        cycle(1'b0);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
